// File: rtl/cla_share_arbiter.sv
// Two-client arbiter/sequencer sharing one combinational W-bit adder; one grant per two cycles.
// Build option: CLA_ARB_FIXED_PRIO_EN selects fixed priority (client 0 first) instead of round-robin.

module cla_share_arb_rsp #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic [W:0]   sum_in,
  input  logic         rsp_ready,
  output logic         rsp_valid,
  output logic [W:0]   rsp_sum
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
    end else if (cap) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum_in;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

module cla_share_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W:0]   rsp0_sum,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W:0]   rsp1_sum,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W:0]   add_sum
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        op_a, op_b;
  logic                gnt_id;
  logic                pref, oth;
  logic [1:0]          req_valid, rsp_valid, rsp_ready, elig, gnt, cap;
  logic [1:0][W:0]     rsp_sum;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign elig      = req_valid & ~rsp_valid;

`ifdef CLA_ARB_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  logic ptr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ptr_q <= 1'b0;
    else if (state_q == ISSUE) ptr_q <= ~gnt_id;
  end
  assign pref = ptr_q;
`endif
  assign oth = ~pref;

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    cap     = '0;
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (elig[pref])     gnt[pref] = 1'b1;
          else if (elig[oth]) gnt[oth]  = 1'b1;
        end
        if (|gnt) state_d = ISSUE;
      end
      ISSUE: begin
        cap[gnt_id] = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      gnt_id  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |gnt) begin
        op_a   <= gnt[1] ? req1_a : req0_a;
        op_b   <= gnt[1] ? req1_b : req0_b;
        gnt_id <= gnt[1];
      end
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign add_a      = op_a;
  assign add_b      = op_b;

  for (genvar g = 0; g < 2; g++) begin : g_rsp
    cla_share_arb_rsp #(.W(W)) u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap       (cap[g]),
      .sum_in    (add_sum),
      .rsp_ready (rsp_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_sum   (rsp_sum[g])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_sum   = rsp_sum[0];
  assign rsp1_sum   = rsp_sum[1];
endmodule
